// File: rtl/sync_pkg.sv
// Shared encodings and limits for the sync_pulse_handshake clock-crossing slice.
package sync_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } src_state_t;

    localparam int SYNC_STAGES_MIN = 2;

    // Fewer than two flops leaves no settling time for a metastable first stage.
    function automatic bit sync_stages_ok(input int stages);
        return stages >= SYNC_STAGES_MIN;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Single-bit multi-flop synchronizer with asynchronous clear.
module sync_ff_chain
    import sync_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (!sync_stages_ok(STAGES)) begin : g_bad_stages
        $error("sync_ff_chain: STAGES must be at least %0d", SYNC_STAGES_MIN);
    end

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sync_pulse_handshake.sv
// Toggle/acknowledge pulse synchronizer from sCLK to dCLK.
// Build option: define SYNC_PULSE_QUEUE_EN to queue requests that arrive while a transfer is in flight.
module sync_pulse_handshake
    import sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int QCNT_W      = 4
) (
    input  logic sCLK,
    input  logic sRST_N,
    input  logic dCLK,
    input  logic sEN,
    output logic sRDY,
    output logic sDROP,
    output logic dPULSE
);

    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_stages
        $error("sync_pulse_handshake: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
    end
    if (QCNT_W < 1) begin : g_bad_qcnt
        $error("sync_pulse_handshake: QCNT_W must be at least 1");
    end

    src_state_t state_q;
    src_state_t state_d;
    logic       tog_q;
    logic       tog_d;
    logic       drop_q;
    logic       drop_d;
    logic       ack_w;
    logic       ack_done;
    logic       dsync_w;
    logic       dlast_q;
    logic       dlast_d;

`ifdef SYNC_PULSE_QUEUE_EN
    localparam logic [QCNT_W-1:0] PEND_MAX = '1;
    localparam logic [QCNT_W-1:0] PEND_ONE = {{(QCNT_W-1){1'b0}}, 1'b1};

    logic [QCNT_W-1:0] pend_q;
    logic [QCNT_W-1:0] pend_d;
`endif

    // The echo matching our toggle means the destination has consumed the event.
    assign ack_done = (ack_w == tog_q);

    always_ff @(posedge sCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            state_q <= S_IDLE;
            tog_q   <= 1'b0;
            drop_q  <= 1'b0;
`ifdef SYNC_PULSE_QUEUE_EN
            pend_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            tog_q   <= tog_d;
            drop_q  <= drop_d;
`ifdef SYNC_PULSE_QUEUE_EN
            pend_q  <= pend_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tog_d   = tog_q;
        drop_d  = 1'b0;
`ifdef SYNC_PULSE_QUEUE_EN
        pend_d  = pend_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sEN) begin
                    tog_d   = ~tog_q;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
`ifdef SYNC_PULSE_QUEUE_EN
                if (ack_done) begin
                    // Relaunch straight from the ack so a queued event never waits in IDLE.
                    if (pend_q != '0) begin
                        tog_d = ~tog_q;
                        if (!sEN) begin
                            pend_d = pend_q - PEND_ONE;
                        end
                    end else if (sEN) begin
                        tog_d = ~tog_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (sEN) begin
                    if (pend_q == PEND_MAX) begin
                        drop_d = 1'b1;
                    end else begin
                        pend_d = pend_q + PEND_ONE;
                    end
                end
`else
                if (ack_done) begin
                    state_d = S_IDLE;
                end
                if (sEN) begin
                    drop_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
`ifdef SYNC_PULSE_QUEUE_EN
        sRDY = (state_q == S_IDLE) && (pend_q == '0);
`else
        sRDY = (state_q == S_IDLE);
`endif
        sDROP = drop_q;
    end

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_fwd_sync (
        .clk   (dCLK),
        .rst_n (sRST_N),
        .d     (tog_q),
        .q     (dsync_w)
    );

    always_comb begin
        dlast_d = dsync_w;
    end

    always_ff @(posedge dCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            dlast_q <= 1'b0;
        end else begin
            dlast_q <= dlast_d;
        end
    end

    // Edge of the synchronized toggle; dlast_q also serves as the echo back to sCLK.
    assign dPULSE = dsync_w ^ dlast_q;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (sCLK),
        .rst_n (sRST_N),
        .d     (dlast_q),
        .q     (ack_w)
    );

endmodule

// File: tb/tb_sync_pulse_handshake.sv
// Directed and randomized checks of sync_pulse_handshake against a transaction-level model.
// Follows SYNC_PULSE_QUEUE_EN the same way the design does.
`timescale 1ps/1ps
module tb_sync_pulse_handshake;

    localparam int STG    = 2;
    localparam int STG3   = 3;
    localparam int QW     = 2;
    localparam int BUDGET = 200;

    logic sCLK   = 1'b0;
    logic dCLK   = 1'b0;
    logic sRST_N = 1'b1;
    logic sEN    = 1'b0;
    logic sEN3   = 1'b0;
    logic sRDY, sDROP, dPULSE;
    logic sRDY3, sDROP3, dPULSE3;

    // sCLK edges land on even picoseconds, dCLK edges on odd ones, so they never coincide.
    int s_half = 5000;
    int d_half = 3500;

    int n_vec  = 0;
    int n_miss = 0;

    int  pulses  = 0;
    int  pulses3 = 0;
    int  n_en    = 0;
    int  n_acc   = 0;
    int  n_drop  = 0;
    int  lost    = 0;
    bit  armed   = 1'b0;
    bit  armed3  = 1'b0;
    bit  busy    = 1'b0;
    int  lat     = 0;
    int  lat3    = 0;
    int  rt_d    = 0;
    int  s_cnt   = 0;
    time t_acc   = 0;
    time t_acc3  = 0;
    logic dp_prev  = 1'b0;
    logic dp3_prev = 1'b0;
    bit  en_prev  = 1'b0;
    bit  rdy_prev = 1'b1;

    sync_pulse_handshake #(
        .SYNC_STAGES (STG),
        .QCNT_W      (QW)
    ) u_dut (
        .sCLK   (sCLK),
        .sRST_N (sRST_N),
        .dCLK   (dCLK),
        .sEN    (sEN),
        .sRDY   (sRDY),
        .sDROP  (sDROP),
        .dPULSE (dPULSE)
    );

    sync_pulse_handshake #(
        .SYNC_STAGES (STG3),
        .QCNT_W      (QW)
    ) u_dut3 (
        .sCLK   (sCLK),
        .sRST_N (sRST_N),
        .dCLK   (dCLK),
        .sEN    (sEN3),
        .sRDY   (sRDY3),
        .sDROP  (sDROP3),
        .dPULSE (dPULSE3)
    );

    initial forever #(s_half) sCLK = ~sCLK;

    initial begin
        #1;
        forever #(d_half) dCLK = ~dCLK;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Events the destination owes: accepted ones, minus any destroyed by a mid-flight reset.
    function automatic int owed();
`ifdef SYNC_PULSE_QUEUE_EN
        return n_en - n_drop - lost;
`else
        return n_acc - lost;
`endif
    endfunction

    initial forever begin
        @(posedge dCLK);
        if ($time > t_acc) begin
            lat++;
            rt_d++;
        end
        if ($time > t_acc3) begin
            lat3++;
        end
    end

    initial forever begin
        @(negedge dCLK);
        if (dPULSE === 1'b1) begin
            pulses++;
            check_val("pulse_width", dp_prev, 0);
`ifndef SYNC_PULSE_QUEUE_EN
            check_val("pulse_expected", armed, 1);
`endif
            if (armed) begin
                check_val("pulse_latency", lat, STG);
            end
            armed = 1'b0;
        end
        dp_prev = dPULSE;
        if (dPULSE3 === 1'b1) begin
            pulses3++;
            check_val("pulse3_width", dp3_prev, 0);
            check_val("pulse3_expected", armed3, 1);
            if (armed3) begin
                check_val("pulse3_latency", lat3, STG3);
            end
            armed3 = 1'b0;
        end
        dp3_prev = dPULSE3;
    end

    // One sCLK cycle: judge the outputs produced by the last edge, then drive the next request.
    task automatic step(input bit en);
        @(negedge sCLK);
`ifdef SYNC_PULSE_QUEUE_EN
        check_val("drop_cause", sDROP & ~(en_prev & ~rdy_prev), 0);
`else
        check_val("drop", sDROP, en_prev & ~rdy_prev);
`endif
        n_drop += (sDROP === 1'b1) ? 1 : 0;
        if (en_prev && rdy_prev) begin
            check_val("busy_after_accept", sRDY, 0);
            busy  = 1'b1;
            s_cnt = 0;
        end else if (busy) begin
            s_cnt++;
            if (sRDY === 1'b1) begin
                check_val("rt_sclk_min", s_cnt >= STG + 1, 1);
                check_val("rt_dclk_min", rt_d >= STG + 1, 1);
                check_val("ack_after_pulse", pulses, owed());
                busy = 1'b0;
            end else if (s_cnt > BUDGET) begin
                check_val("rdy_timeout", s_cnt, BUDGET);
                busy = 1'b0;
            end
        end else begin
            check_val("rdy_idle", sRDY, 1);
        end
        if (en && sRDY === 1'b1) begin
            armed = 1'b1;
            t_acc = $time + s_half;
            lat   = 0;
            rt_d  = 0;
            n_acc++;
        end
        n_en    += en ? 1 : 0;
        en_prev  = en;
        rdy_prev = (sRDY === 1'b1);
        sEN      = en;
    endtask

    task automatic do_reset();
        @(negedge sCLK);
        sEN    = 1'b0;
        sEN3   = 1'b0;
        sRST_N = 1'b0;
        #2;
        check_val("rst_rdy", sRDY, 1);
        check_val("rst_drop", sDROP, 0);
        check_val("rst_pulse", dPULSE, 0);
        check_val("rst_rdy3", sRDY3, 1);
        armed    = 1'b0;
        armed3   = 1'b0;
        busy     = 1'b0;
        en_prev  = 1'b0;
        rdy_prev = 1'b1;
        repeat (2) @(negedge sCLK);
        sRST_N = 1'b1;
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0, d0, a0, cnt;

        // Single event, 10 ns / 7 ns clocks
        do_reset();
        p0 = pulses;
        d0 = n_drop;
        step(1'b1);
        repeat (20) step(1'b0);
        check_val("t1_pulses", pulses - p0, 1);
        check_val("t1_drops", n_drop - d0, 0);
        check_val("t1_rdy", sRDY, 1);

        // Three back-to-back requests
        p0 = pulses;
        d0 = n_drop;
        repeat (3) step(1'b1);
        repeat (25) step(1'b0);
`ifdef SYNC_PULSE_QUEUE_EN
        check_val("t2_pulses", pulses - p0, 3);
        check_val("t2_drops", n_drop - d0, 0);
`else
        check_val("t2_pulses", pulses - p0, 1);
        check_val("t2_drops", n_drop - d0, 2);
`endif

`ifdef SYNC_PULSE_QUEUE_EN
        // Queue overflow with a slow destination so no ack lands inside the burst
        do_reset();
        d_half = 40000;
        p0 = pulses;
        d0 = n_drop;
        repeat (5) step(1'b1);
        repeat (150) step(1'b0);
        check_val("t3_pulses", pulses - p0, 4);
        check_val("t3_drops", n_drop - d0, 1);
        check_val("t3_rdy", sRDY, 1);
        d_half = 3500;
`endif

        // Reset one dCLK edge after acceptance, before the pulse can form
        do_reset();
        p0 = pulses;
        step(1'b1);
        @(posedge sCLK);
        @(posedge dCLK);
        #2;
        sRST_N = 1'b0;
        sEN    = 1'b0;
        #2;
        check_val("t4_rdy", sRDY, 1);
        check_val("t4_drop", sDROP, 0);
        check_val("t4_pulse", dPULSE, 0);
        check_val("t4_early", pulses - p0, 0);
        armed    = 1'b0;
        busy     = 1'b0;
        en_prev  = 1'b0;
        rdy_prev = 1'b1;
        lost++;
        repeat (2) @(negedge sCLK);
        sRST_N = 1'b1;
        repeat (20) step(1'b0);
        check_val("t4_no_pulse", pulses - p0, 0);
        step(1'b1);
        repeat (20) step(1'b0);
        check_val("t4_recover", pulses - p0, 1);

        // Random requests with dCLK about 8x faster, then 8x slower, than sCLK
        for (int r = 0; r < 2; r++) begin
            do_reset();
            d_half = (r == 0) ? 626 : 40000;
            p0  = pulses;
            a0  = owed();
            cnt = 0;
            while (cnt < 100) begin
                bit e;
                e = ($urandom_range(0, 3) == 0);
                step(e);
                cnt += e ? 1 : 0;
            end
            repeat (150) step(1'b0);
            check_val(r == 0 ? "t5_fast_count" : "t5_slow_count", pulses - p0, owed() - a0);
        end
        d_half = 3500;

        // Three-stage instance: pulse after the third dCLK edge
        do_reset();
        p0 = pulses3;
        @(negedge sCLK);
        check_val("t6_rdy3", sRDY3, 1);
        sEN3   = 1'b1;
        armed3 = 1'b1;
        t_acc3 = $time + s_half;
        lat3   = 0;
        @(negedge sCLK);
        sEN3 = 1'b0;
        check_val("t6_busy3", sRDY3, 0);
        repeat (30) @(negedge sCLK);
        check_val("t6_pulses3", pulses3 - p0, 1);
        check_val("t6_rdy3_back", sRDY3, 1);
        check_val("t6_drop3", sDROP3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
